// File: rtl/block_combine_pkg.sv
// Shared constants and width helpers for the block_combine 2-phase buffer.
// Optional input synchronizers are enabled with `define BLOCK_COMBINE_SYNC_EN.
package block_combine_pkg;

    localparam int DATA_WIDTH_DEF = 3;
    localparam int DEPTH_DEF      = 2;

    function automatic int occ_width(input int depth);
        return $clog2(depth + 1);
    endfunction

    function automatic int ptr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/block_combine_phase_detect.sv
// 2-phase edge detector: samples a handshake wire into a phase flop and flags an
// event while it differs from the reference. BLOCK_COMBINE_SYNC_EN adds a metastability flop.
module phase_detect
    import block_combine_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic sig_in,
    input  logic ref_upd,
    output logic evt,
    output logic ref_o
);

    logic phase_q, phase_d;
    logic ref_q, ref_d;

`ifdef BLOCK_COMBINE_SYNC_EN
    logic meta_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) meta_q <= 1'b0;
        else        meta_q <= sig_in;
    end

    always_comb phase_d = meta_q;
`else
    always_comb phase_d = sig_in;
`endif

    always_comb begin
        ref_d = ref_upd ? phase_q : ref_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_q <= 1'b0;
            ref_q   <= 1'b0;
        end else begin
            phase_q <= phase_d;
            ref_q   <= ref_d;
        end
    end

    assign evt   = phase_q != ref_q;
    assign ref_o = ref_q;

endmodule

// File: rtl/block_combine.sv
// 2-phase bundled-data FIFO buffer of DEPTH stages between two handshake channels.
// Define BLOCK_COMBINE_SYNC_EN to pass req_in/ack_in through 2-flop synchronizers.
module block_combine
    import block_combine_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int DEPTH      = DEPTH_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_in,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic                  ack_out,
    output logic                  req_out,
    output logic [DATA_WIDTH-1:0] data_out,
    input  logic                  ack_in
);

    localparam int OCC_W = occ_width(DEPTH);
    localparam int PTR_W = ptr_width(DEPTH);
    localparam logic [OCC_W-1:0] DEPTH_C  = OCC_W'(DEPTH);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);

    logic req_evt, ack_evt, req_ref, ack_ref;
    logic push, pop, launch, outstanding;

    logic [OCC_W-1:0]      count_q, count_d;
    logic [PTR_W-1:0]      head_q, head_d, tail_q, tail_d;
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] mem_d [DEPTH];
    logic                  req_out_q, req_out_d;
    logic [DATA_WIDTH-1:0] data_out_q, data_out_d;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_LAST) ? '0 : p + 1'b1;
    endfunction

    // The req reference toggles exactly when a token is accepted, so it doubles as ack_out.
    phase_detect u_req_pd (
        .clk     (clk),
        .rst_n   (rst_n),
        .sig_in  (req_in),
        .ref_upd (push),
        .evt     (req_evt),
        .ref_o   (req_ref)
    );

    phase_detect u_ack_pd (
        .clk     (clk),
        .rst_n   (rst_n),
        .sig_in  (ack_in),
        .ref_upd (ack_evt),
        .evt     (ack_evt),
        .ref_o   (ack_ref)
    );

    always_comb begin
        outstanding = req_out_q != ack_ref;
        pop         = ack_evt && outstanding && (count_q != '0);
        // A pop in the same cycle frees the slot the push needs, even when full.
        push        = req_evt && ((count_q != DEPTH_C) || pop);
        launch      = !outstanding && (count_q != '0);

        head_d = pop  ? ptr_inc(head_q) : head_q;
        tail_d = push ? ptr_inc(tail_q) : tail_q;

        mem_d = mem_q;
        if (push) mem_d[tail_q] = data_in;

        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        req_out_d  = launch ? ~req_out_q     : req_out_q;
        data_out_d = launch ? mem_q[head_q]  : data_out_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q    <= '0;
            head_q     <= '0;
            tail_q     <= '0;
            req_out_q  <= 1'b0;
            data_out_q <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            count_q    <= count_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            req_out_q  <= req_out_d;
            data_out_q <= data_out_d;
            mem_q      <= mem_d;
        end
    end

    assign ack_out  = req_ref;
    assign req_out  = req_out_q;
    assign data_out = data_out_q;

endmodule

// File: tb/tb_block_combine.sv
// Scoreboard bench for block_combine: tokens issued upstream are queued as expected
// launches; a monitor pops and compares on every req_out toggle.
module tb_block_combine;

    localparam int DW = 3;
    localparam int DP = 2;
`ifdef BLOCK_COMBINE_SYNC_EN
    localparam int DET = 2;
`else
    localparam int DET = 1;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          req_in = 1'b0;
    logic          ack_in = 1'b0;
    logic [DW-1:0] data_in = '0;
    logic          ack_out, req_out;
    logic [DW-1:0] data_out;

    int checks = 0, failures = 0, launches = 0, acks = 0;
    bit auto_ack = 1'b0;
    logic [DW-1:0] exp_q[$];
    logic prev_req = 1'b0, prev_ack = 1'b0;

    block_combine #(.DATA_WIDTH(DW), .DEPTH(DP)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req_in   (req_in),
        .data_in  (data_in),
        .ack_out  (ack_out),
        .req_out  (req_out),
        .data_out (data_out),
        .ack_in   (ack_in)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    // Monitor: every req_out toggle must deliver the oldest issued token.
    initial forever begin
        @(negedge clk);
        if (!rst_n) begin
            prev_req = 1'b0;
            prev_ack = 1'b0;
        end else begin
            if (ack_out !== prev_ack) begin
                acks++;
                prev_ack = ack_out;
            end
            if (req_out !== prev_req) begin
                launches++;
                prev_req = req_out;
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL launch_no_token actual=%0d expected=none", data_out);
                end else begin
                    check("launch_data", data_out, exp_q.pop_front());
                end
            end
        end
    end

    // Downstream responder: acknowledges each launched token after a random delay.
    initial forever begin
        int d;
        @(negedge clk);
        if (auto_ack && rst_n && req_out !== ack_in) begin
            d = $urandom_range(0, 3);
            repeat (d) @(negedge clk);
            if (auto_ack && rst_n) ack_in = req_out;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic issue(input logic [DW-1:0] d);
        data_in = d;
        req_in  = ~req_in;
        exp_q.push_back(d);
    endtask

    task automatic wait_ack();
        int n = 0;
        while (ack_out !== req_in && n < 100) begin
            tick(1);
            n++;
        end
        check("ack_handshake", ack_out, req_in);
    endtask

    task automatic drain();
        int n = 0;
        while (!(exp_q.size() == 0 && req_out === ack_in) && n < 500) begin
            tick(1);
            n++;
        end
        check("drain_queue", exp_q.size(), 0);
    endtask

    task automatic do_reset(input logic req_lvl);
        rst_n    = 1'b0;
        auto_ack = 1'b0;
        ack_in   = 1'b0;
        req_in   = req_lvl;
        exp_q.delete();
        tick(2);
        check("reset_outputs", {req_out, ack_out, data_out}, 0);
        rst_n = 1'b1;
    endtask

    initial begin
        int l0, a0, ntok;
        logic [DW-1:0] last;

        // First token: detect latency, ack at E, launch at E+1
        do_reset(1'b0);
        tick(1);
        issue(3'd1);
        tick(DET);
        check("detect_latency_ack", ack_out, 0);
        tick(1);
        check("ack_toggle_edge", ack_out, 1);
        check("launch_not_early", req_out, 0);
        tick(1);
        check("launch_edge_req", req_out, 1);
        check("launch_edge_data", data_out, 1);
        auto_ack = 1'b1;
        drain();

        // Five alternating tokens with downstream acking each launch
        do_reset(1'b0);
        auto_ack = 1'b1;
        l0 = launches; a0 = acks; ntok = 5;
        for (int i = 1; i <= ntok; i++) begin
            issue(DW'(i));
            wait_ack();
        end
        drain();
        check("seq_launch_count", launches - l0, ntok);
        check("seq_ack_count", acks - a0, ntok);

        // Spurious ack with the FIFO empty must not disturb any output
        auto_ack = 1'b0;
        tick(2);
        l0 = launches;
        ack_in = ~ack_in;
        tick(6);
        check("spurious_req_out", req_out, ntok % 2);
        check("spurious_data_out", data_out, ntok);
        check("spurious_ack_out", ack_out, ntok % 2);
        check("spurious_no_launch", launches - l0, 0);

        // req_in already high when reset releases counts as a token
        data_in = 3'd6;
        do_reset(1'b1);
        exp_q.push_back(3'd6);
        auto_ack = 1'b1;
        wait_ack();
        drain();

        // Randomized traffic
        do_reset(1'b0);
        auto_ack = 1'b1;
        l0 = launches; a0 = acks;
        for (int i = 0; i < 40; i++) begin
            issue(DW'($urandom_range(0, (1 << DW) - 1)));
            wait_ack();
            tick($urandom_range(0, 3));
        end
        drain();
        check("rand_launch_count", launches - l0, 40);
        check("rand_ack_count", acks - a0, 40);

        // Full FIFO with downstream stalled: third token waits for space
        do_reset(1'b0);
        a0 = acks;
        issue(3'd1); wait_ack();
        issue(3'd2); wait_ack();
        issue(3'd3);
        tick(8);
        check("full_stall_ack_out", ack_out, !req_in);
        check("full_stall_ack_count", acks - a0, 2);
        ack_in = req_out;
        wait_ack();
        check("full_release_ack_count", acks - a0, 3);
        tick(3);
        check("full_release_data", data_out, 2);
        auto_ack = 1'b1;
        drain();

        // Full FIFO, push and pop in the same cycle
        do_reset(1'b0);
        l0 = launches;
        issue(3'd4); wait_ack();
        issue(3'd5); wait_ack();
        tick(3);
        issue(3'd6);
        ack_in = req_out;
        tick(DET + 1);
        check("simul_push_ack", ack_out, req_in);
        auto_ack = 1'b1;
        drain();
        check("simul_launch_count", launches - l0, 3);

        // Reset mid-transfer discards stored tokens
        do_reset(1'b0);
        issue(3'd7); wait_ack();
        issue(3'd2); wait_ack();
        tick(2);
        last = data_out;
        check("pre_reset_data", last, 7);
        rst_n = 1'b0;
        #1;
        check("async_reset_req_out", req_out, 0);
        check("async_reset_ack_out", ack_out, 0);
        check("async_reset_data_out", data_out, 0);
        exp_q.delete();
        req_in = 1'b0;
        ack_in = 1'b0;
        l0 = launches; a0 = acks;
        tick(2);
        rst_n = 1'b1;
        tick(10);
        check("post_reset_no_launch", launches - l0, 0);
        check("post_reset_no_ack", acks - a0, 0);
        check("post_reset_req_out", req_out, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/block_combine.md
BLOCK_COMBINE -- requirements
Module: block_combine

Interface
REQ-001 The module SHALL provide parameter DATA_WIDTH, default 3, defining the payload width in bits.
REQ-002 The module SHALL provide parameter DEPTH, default 2, defining the number of combined buffer stages (legal range 1..16).
REQ-003 clk  input  1  single system clock; all state on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous and active-low.
REQ-005 req_in  input  1  upstream 2-phase request; every level transition is one new token.
REQ-006 data_in  input  DATA_WIDTH  upstream bundled data; stable from before a req_in transition until the matching ack_out transition.
REQ-007 ack_out  output  1  upstream 2-phase acknowledge; toggles once per accepted token.
REQ-008 req_out  output  1  downstream 2-phase request; toggles once per launched token.
REQ-009 data_out  output  DATA_WIDTH  downstream bundled data; stable while a launched token is unacknowledged.
REQ-010 ack_in  input  1  downstream 2-phase acknowledge; each transition retires the outstanding token.

Function
REQ-011 req_in and ack_in SHALL each be registered into a phase value; an event SHALL be detected when the phase value differs from its stored reference phase.
REQ-012 On a req event with occupancy < DEPTH, the block SHALL write data_in into the FIFO tail, update the req reference, and toggle ack_out on the same clock edge.
REQ-013 On a req event with occupancy == DEPTH, the event SHALL remain pending, with the reference unchanged and ack_out unchanged, until space frees.
REQ-014 A token is outstanding while req_out != ack reference; when no token is outstanding and the FIFO is non-empty, the block SHALL drive data_out with the head entry and toggle req_out on the same edge.
REQ-015 On an ack event with a token outstanding, the block SHALL pop the head and update the ack reference; the next launch SHALL occur no earlier than the following cycle.
REQ-016 An ack event with no token outstanding SHALL be ignored except for updating the ack reference.
REQ-017 Simultaneous push and pop in one cycle SHALL both occur, including when full, and occupancy SHALL remain unchanged.
REQ-018 Pointers SHALL wrap modulo DEPTH; occupancy SHALL use $clog2(DEPTH+1) bits and never exceed DEPTH or underflow.
REQ-019 data_out SHALL hold its last value when no token is outstanding.
REQ-020 Latency with an empty FIFO SHALL be as follows: ack_out toggles at event-detect edge E, and req_out toggles at E+1.

Reset
REQ-021 While rst_n = 0, the block SHALL force req_out=0, ack_out=0, data_out=0, occupancy 0, pointers 0, both phase registers 0 and both references 0.
REQ-022 Reset asserted mid-transfer SHALL discard all stored tokens immediately.
REQ-023 If req_in is 1 when reset releases, this SHALL count as one req event.

Configuration
REQ-024 With macro BLOCK_COMBINE_SYNC_EN defined, req_in and ack_in SHALL each pass through a 2-flop synchronizer, adding 1 cycle of detect latency versus the undefined case.
REQ-025 With BLOCK_COMBINE_SYNC_EN undefined, req_in and ack_in SHALL be sampled by a single flop and the inputs SHALL be treated as synchronous to clk.

Structure
REQ-026 A shared package block_combine_pkg SHALL hold the default DATA_WIDTH and DEPTH constants and the occupancy-width function.
REQ-027 A sub-module phase_detect (optional synchronizer, phase register, reference register, event output) SHALL be instantiated once for req_in and once for ack_in.

Verification
REQ-028 Reset then req_in 0->1 with data_in=1 -> ack_out 0->1 and req_out 0->1 one cycle later with data_out=1.
REQ-029 Alternating tokens 1..5 via req_in 1,0,1,0,1, with ack_in toggled after each req_out -> data_out sequence 1,2,3,4,5 and exactly 5 toggles each of ack_out and req_out.
REQ-030 DEPTH=2 with ack_in held: send 3 tokens (1,2,3) -> ack_out toggles twice only; one ack_in toggle -> third ack_out toggle, and data_out becomes 2.
REQ-031 Full FIFO with a req event and an ack event in the same cycle -> one push and one pop, occupancy stays 2, no token lost.
REQ-032 Spurious ack_in toggle with FIFO empty -> no change on req_out, data_out or ack_out.
REQ-033 rst_n pulsed low with 2 tokens stored -> all outputs 0 asynchronously, and after release with req_in=0 no token is emitted.
